countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Minutes:seconds countdown timer, the down-counting counterpart of the stopwatch block in the same timekeeping subsystem.
- Firmware or pushbuttons load a preset MM:SS value, then start, pause and resume the countdown.
- On reaching 00:00 the block halts, raises a sticky done flag and emits a one-cycle alarm pulse for the buzzer/LED driver.

Parameters:
- DIV_MAX, 11_999_999, terminal count of the 1 Hz prescaler. One tick every DIV_MAX+1 clk cycles (12 MHz clk gives 1 s).
- DIV_W, 24, prescaler counter width. Must satisfy 2^DIV_W > DIV_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; captures load_min/load_sec.
- load_min  input  6  preset minutes, 0..59; values >59 are clamped to 59.
- load_sec  input  6  preset seconds, 0..59; values >59 are clamped to 59.
- start  input  1  begin or resume the countdown.
- stop  input  1  pause the countdown.
- min  output  6  current minutes remaining.
- sec  output  6  current seconds remaining.
- running  output  1  high while in RUN.
- done  output  1  high while in EXPIRED (sticky).
- alarm  output  1  one-cycle pulse on the cycle the count reaches 00:00.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, min=0, sec=0, prescaler=0, running=0, done=0, alarm=0.
- State encoding and outputs:
  - States: IDLE, RUN, PAUSED, EXPIRED.
  - running = (state==RUN); done = (state==EXPIRED). Both are registered and decoded from state.
- Command priority when several are high in one cycle: load > stop > start.
- load (any state):
  - min/sec <= clamped inputs, prescaler <= 0, state <= IDLE.
  - Any pending tick in that cycle is discarded; alarm stays 0.
- start:
  - IDLE or PAUSED with (min,sec) != (0,0): state <= RUN, prescaler <= 0.
  - First decrement occurs DIV_MAX+1 cycles after the start cycle.
  - Ignored in RUN, in EXPIRED, and when the count is 00:00.
- stop:
  - In RUN: state <= PAUSED; prescaler frozen (not cleared); min/sec hold.
  - Ignored in every other state.
- Prescaler:
  - Increments only in RUN; wraps DIV_MAX -> 0.
  - tick = (state==RUN && prescaler==DIV_MAX && no load/stop this cycle).
- On tick (decrement):
  - sec>0: sec <= sec-1.
  - sec==0 and min>0: sec <= 59, min <= min-1.
  - Never underflows; 00:00 is never decremented because RUN is not entered at 00:00.
- Expiry:
  - When a tick takes the count from 00:01 to 00:00: state <= EXPIRED, and alarm is high for exactly the next cycle (registered, coincident with min/sec showing 0).
- EXPIRED:
  - Holds 00:00, done=1, prescaler=0.
  - Left only by load or reset; start and stop are ignored.
- Width rules:
  - min/sec are 6-bit unsigned and never exceed 59.
  - Clamping is combinational on the load inputs before capture.
- Asynchronous reset mid-count or while alarm is high:
  - All outputs return to reset values immediately; no alarm is generated afterwards.

Test Plan:
- DIV_MAX=3, reset released, load 00:03, start -> running=1; sec reads 2, 1, 0 at 4-cycle intervals; alarm high exactly 1 cycle with sec=0; done=1, running=0; alarm low thereafter.
- DIV_MAX=3, load 01:00, start, one tick -> min=0, sec=59 in the same cycle; no alarm.
- DIV_MAX=3, load 00:10, start, stop at prescaler=2, wait 20 cycles, start -> count frozen at pause; after resume, next decrement exactly 4 cycles after start (prescaler restarted at 0).
- load with load_min=63, load_sec=60 -> min=59, sec=59, state IDLE; start with count 00:00 after reset -> running stays 0, done stays 0.
- Simultaneous load+start, and separately stop+start in RUN -> load wins (IDLE, new value captured); stop wins (PAUSED).
- Assert rst_n low mid-RUN at 00:01, one cycle before the expiring tick -> min=sec=0, running=0, done=0, alarm never asserted; in EXPIRED, start has no effect and load 00:05 returns to IDLE with done=0.

Source files
------------

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with a 1 Hz prescaler.
// Counts a loaded MM:SS preset down to 00:00, then halts with a sticky done flag
// and a single-cycle alarm pulse. Commands resolve as load > stop > start.
module countdown_timer #(
  parameter int unsigned DIV_MAX = 11_999_999,
  parameter int unsigned DIV_W   = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [DIV_W-1:0] DivMax = DIV_W'(DIV_MAX);
  localparam logic [5:0]       MaxVal = 6'd59;

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] presc_q;
  logic [5:0]       min_q, sec_q;
  logic             running_q, done_q, alarm_q;

  logic [5:0] min_clamped, sec_clamped;
  logic       count_zero;
  logic       start_ok;
  logic       tick;

  // Clamp the preset inputs and decode the qualified start and tick conditions.
  always_comb begin
    min_clamped = (load_min > MaxVal) ? MaxVal : load_min;
    sec_clamped = (load_sec > MaxVal) ? MaxVal : load_sec;
    count_zero  = (min_q == 6'd0) && (sec_q == 6'd0);
    start_ok    = start && !count_zero && ((state_q == StIdle) || (state_q == StPaused));
    tick        = (state_q == StRun) && (presc_q == DivMax) && !load && !stop;
  end

  // Single FSM: state, prescaler, count and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      // Alarm is a pulse; only the expiring tick re-asserts it.
      alarm_q <= 1'b0;
      if (load) begin
        min_q     <= min_clamped;
        sec_q     <= sec_clamped;
        presc_q   <= '0;
        state_q   <= StIdle;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (stop) begin
        // Stop masks start; the prescaler keeps its phase while paused.
        if (state_q == StRun) begin
          state_q   <= StPaused;
          running_q <= 1'b0;
        end
      end else if (start_ok) begin
        // Resuming restarts the prescaler so the next decrement is a full period away.
        state_q   <= StRun;
        presc_q   <= '0;
        running_q <= 1'b1;
      end else if (state_q == StRun) begin
        if (tick) begin
          presc_q <= '0;
          if (sec_q != 6'd0) begin
            sec_q <= sec_q - 6'd1;
          end else if (min_q != 6'd0) begin
            sec_q <= MaxVal;
            min_q <= min_q - 6'd1;
          end
          if ((min_q == 6'd0) && (sec_q == 6'd1)) begin
            state_q   <= StExpired;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            alarm_q   <= 1'b1;
          end
        end else begin
          presc_q <= presc_q + DIV_W'(1);
        end
      end
    end
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a small prescaler (DIV_MAX=3).
// Expected status words are queued when stimulus is applied and compared as
// the DUT produces them, one per cycle, #1 after the rising edge.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;
  logic [5:0] min;
  logic [5:0] sec;
  logic       running;
  logic       done;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];

  logic [14:0] obs;
  assign obs = {min, sec, running, done, alarm};

  countdown_timer #(
    .DIV_MAX(3),
    .DIV_W  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_min(load_min),
    .load_sec(load_sec),
    .start   (start),
    .stop    (stop),
    .min     (min),
    .sec     (sec),
    .running (running),
    .done    (done),
    .alarm   (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [14:0] st(input int m, input int s, input bit r, input bit d,
                                     input bit a);
    return {6'(m), 6'(s), r, d, a};
  endfunction

  task automatic push(input string tag, input logic [14:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_n(input string tag, input logic [14:0] val, input int n);
    for (int i = 0; i < n; i++) push(tag, val);
  endtask

  task automatic check_now();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h required=<queued expectation>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_chk(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      check_now();
    end
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] s);
    load_min = m;
    load_sec = s;
    load     = 1'b1;
    cyc();
    load     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    load_min = '0;
    load_sec = '0;
    start    = 1'b0;
    stop     = 1'b0;
    repeat (2) cyc();
    push("reset", st(0, 0, 0, 0, 0));
    check_now();
    rst_n = 1'b1;

    // Full countdown from 00:03 through expiry.
    do_load(6'd0, 6'd3);
    push("load_0003", st(0, 3, 0, 0, 0));
    check_now();
    pulse_start();
    push("start_0003", st(0, 3, 1, 0, 0));
    check_now();
    for (int i = 1; i <= 12; i++) begin
      int s;
      s = (i < 4) ? 3 : (i < 8) ? 2 : (i < 12) ? 1 : 0;
      push("count_0003", st(0, s, i < 12, i == 12, i == 12));
    end
    run_chk(12);
    push_n("expired_hold", st(0, 0, 0, 1, 0), 3);
    run_chk(3);

    // Minute borrow: 01:00 -> 00:59 on the first tick, no alarm.
    do_load(6'd1, 6'd0);
    push("load_0100", st(1, 0, 0, 0, 0));
    check_now();
    pulse_start();
    push_n("run_0100", st(1, 0, 1, 0, 0), 4);
    push("borrow", st(0, 59, 1, 0, 0));
    check_now();
    run_chk(4);

    // Pause at prescaler=2, hold 20 cycles, resume restarts the full period.
    do_load(6'd0, 6'd10);
    push("load_0010", st(0, 10, 0, 0, 0));
    check_now();
    pulse_start();
    push_n("run_0010", st(0, 10, 1, 0, 0), 3);
    check_now();
    run_chk(2);
    pulse_stop();
    push_n("paused", st(0, 10, 0, 0, 0), 21);
    check_now();
    run_chk(20);
    pulse_start();
    push_n("resume", st(0, 10, 1, 0, 0), 4);
    push("resume_tick", st(0, 9, 1, 0, 0));
    check_now();
    run_chk(4);

    // Clamp out-of-range preset, then start at 00:00 after reset is ignored.
    do_load(6'd63, 6'd60);
    push("clamp", st(59, 59, 0, 0, 0));
    check_now();
    rst_n = 1'b0;
    #2;
    push("async_rst", st(0, 0, 0, 0, 0));
    check_now();
    cyc();
    rst_n = 1'b1;
    pulse_start();
    push_n("start_zero", st(0, 0, 0, 0, 0), 4);
    check_now();
    run_chk(3);

    // load beats start; stop beats start while running.
    do_load(6'd0, 6'd5);
    pulse_start();
    push("run_0005", st(0, 5, 1, 0, 0));
    check_now();
    load_min = 6'd2;
    load_sec = 6'd7;
    load     = 1'b1;
    start    = 1'b1;
    cyc();
    load     = 1'b0;
    start    = 1'b0;
    push("load_wins", st(2, 7, 0, 0, 0));
    check_now();
    pulse_start();
    push("run_0207", st(2, 7, 1, 0, 0));
    check_now();
    stop  = 1'b1;
    start = 1'b1;
    cyc();
    stop  = 1'b0;
    start = 1'b0;
    push_n("stop_wins", st(2, 7, 0, 0, 0), 5);
    check_now();
    run_chk(4);

    // Reset one cycle before the expiring tick: no alarm afterwards.
    do_load(6'd0, 6'd2);
    pulse_start();
    push_n("run_0002", st(0, 2, 1, 0, 0), 4);
    push_n("run_0001", st(0, 1, 1, 0, 0), 4);
    check_now();
    run_chk(7);
    rst_n = 1'b0;
    #2;
    push_n("rst_mid", st(0, 0, 0, 0, 0), 2);
    check_now();
    cyc();
    check_now();
    cyc();
    rst_n = 1'b1;
    push_n("no_alarm", st(0, 0, 0, 0, 0), 6);
    run_chk(6);

    // EXPIRED ignores start/stop; load leaves it.
    do_load(6'd0, 6'd1);
    pulse_start();
    push_n("run_0001b", st(0, 1, 1, 0, 0), 4);
    push("expire_b", st(0, 0, 0, 1, 1));
    check_now();
    run_chk(4);
    pulse_start();
    push("exp_start", st(0, 0, 0, 1, 0));
    check_now();
    pulse_stop();
    push("exp_stop", st(0, 0, 0, 1, 0));
    check_now();
    do_load(6'd0, 6'd5);
    push("exp_load", st(0, 5, 0, 0, 0));
    check_now();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
